// File: rtl/exec_pkg.sv
// Shared types and width constants for the execute stage.
package exec_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int PC_W_DEF   = 31;
    localparam int ADDR_W_DEF = 32;
    localparam int ALU_OP_W   = 5;
    localparam int SH_W       = 4;
    localparam int REG_W      = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 5'd0,
        ALU_SUB   = 5'd1,
        ALU_LOGIC = 5'd2,
        ALU_SHL   = 5'd3,
        ALU_SHR   = 5'd4,
        ALU_SRA   = 5'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_MEM_REQ  = 2'd2,
        ST_MEM_WAIT = 2'd3
    } exec_state_e;

    function automatic logic is_shift_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_SHL) || (op == ALU_SHR) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle ALU: add, subtract and truth-table logic. Shifts are handled by the caller.
module exec_alu
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [3:0]          truth_table,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic [DATA_W-1:0]   result
);

    // Evaluate the selected op; anything else yields zero
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_LOGIC: begin
                for (int i = 0; i < DATA_W; i++) begin
                    result[i] = truth_table[{a[i], b[i]}];
                end
            end
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, serial shifter, memory port and branch redirect.
module execute
    import exec_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                src_a_en,
    input  logic                src_b_en,
    input  logic [DATA_W-1:0]   src_a,
    input  logic [DATA_W-1:0]   src_b,
    input  logic                i_alu_en,
    input  logic [3:0]          i_truth_table,
    input  logic [ALU_OP_W-1:0] i_alu_op,
    input  logic [SH_W-1:0]     sh_off,
    input  logic                i_mem_en,
    input  logic                i_mem_write,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic                i_pc_set,
    input  logic                i_pc_add,
    input  logic                i_pc_inc,
    input  logic [PC_W-1:0]     pc,
    input  logic [REG_W-1:0]    i_dst_reg,
    input  logic                i_wr_en,
    output logic                exe_stall,
    output logic [DATA_W-1:0]   exe_out,
    output logic [REG_W-1:0]    exe_dst_reg,
    output logic                exe_en,
    output logic                redirect_valid,
    output logic [PC_W-1:0]     redirect_pc,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic                mem_req_we,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    exec_state_e            state_r;
    logic                   stall_r;
    logic [DATA_W-1:0]      exe_out_r;
    logic [REG_W-1:0]       dst_r;
    logic                   exe_en_r;
    logic                   wr_en_r;
    logic                   redirect_valid_r;
    logic [PC_W-1:0]        redirect_pc_r;
    logic                   req_valid_r;
    logic [ADDR_W-1:0]      req_addr_r;
    logic                   req_we_r;
    logic [DATA_W-1:0]      req_wdata_r;
    logic [DATA_W-1:0]      shift_val_r;
    logic [SH_W-1:0]        shift_cnt_r;
    logic [ALU_OP_W-1:0]    shift_op_r;

    logic                   present_s;
    logic                   multi_shift_s;
    logic [DATA_W-1:0]      alu_res_s;
    logic [DATA_W-1:0]      single_res_s;
    logic [DATA_W-1:0]      shift_next_s;
    logic                   unused_s;

    // Operand-valid flags are already resolved by read before issue.
    assign unused_s = src_a_en ^ src_b_en;

    assign present_s     = i_alu_en | i_mem_en | i_pc_set | i_pc_add | i_pc_inc;
    assign multi_shift_s = is_shift_op(i_alu_op) && (sh_off != 4'd0);

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .truth_table (i_truth_table),
        .alu_op      (i_alu_op),
        .result      (alu_res_s)
    );

    // Single-cycle result; a zero-distance shift passes the operand through
    always_comb begin
        single_res_s = alu_res_s;
        if (is_shift_op(i_alu_op)) begin
            single_res_s = src_a;
        end else begin
            single_res_s = alu_res_s;
        end
    end

    // One-bit step of the serial shifter
    always_comb begin
        shift_next_s = shift_val_r;
        case (shift_op_r)
            ALU_SHL: shift_next_s = {shift_val_r[DATA_W-2:0], 1'b0};
            ALU_SHR: shift_next_s = {1'b0, shift_val_r[DATA_W-1:1]};
            ALU_SRA: shift_next_s = {shift_val_r[DATA_W-1], shift_val_r[DATA_W-1:1]};
            default: shift_next_s = shift_val_r;
        endcase
    end

    // Control FSM with all outputs registered
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state_r          <= ST_IDLE;
            stall_r          <= 1'b0;
            exe_out_r        <= '0;
            dst_r            <= '0;
            exe_en_r         <= 1'b0;
            wr_en_r          <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
            req_valid_r      <= 1'b0;
            req_addr_r       <= '0;
            req_we_r         <= 1'b0;
            req_wdata_r      <= '0;
            shift_val_r      <= '0;
            shift_cnt_r      <= '0;
            shift_op_r       <= '0;
        end else begin
            exe_en_r         <= 1'b0;
            redirect_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (present_s) begin
                        dst_r            <= i_dst_reg;
                        wr_en_r          <= i_wr_en;
                        redirect_valid_r <= i_pc_set | i_pc_add;
                        if (i_pc_set | i_pc_add) begin
                            redirect_pc_r <= pc;
                        end
                        if (i_mem_en) begin
                            req_valid_r <= 1'b1;
                            req_addr_r  <= mem_addr;
                            req_we_r    <= i_mem_write;
                            req_wdata_r <= src_b;
                            state_r     <= ST_MEM_REQ;
                            stall_r     <= 1'b1;
                        end else if (i_alu_en && multi_shift_s) begin
                            shift_val_r <= src_a;
                            shift_cnt_r <= sh_off;
                            shift_op_r  <= i_alu_op;
                            state_r     <= ST_SHIFT;
                            stall_r     <= 1'b1;
                        end else if (i_alu_en && i_wr_en) begin
                            exe_out_r <= single_res_s;
                            exe_en_r  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_val_r <= shift_next_s;
                    shift_cnt_r <= shift_cnt_r - 4'd1;
                    if (shift_cnt_r == 4'd1) begin
                        if (wr_en_r) begin
                            exe_out_r <= shift_next_s;
                        end
                        exe_en_r <= wr_en_r;
                        state_r  <= ST_IDLE;
                        stall_r  <= 1'b0;
                    end
                end
                ST_MEM_REQ: begin
                    if (mem_req_ready) begin
                        req_valid_r <= 1'b0;
                        if (req_we_r) begin
                            state_r <= ST_IDLE;
                            stall_r <= 1'b0;
                        end else begin
                            state_r <= ST_MEM_WAIT;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (wr_en_r) begin
                            exe_out_r <= mem_rsp_data;
                        end
                        exe_en_r <= wr_en_r;
                        state_r  <= ST_IDLE;
                        stall_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    stall_r     <= 1'b0;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign exe_stall      = stall_r;
    assign exe_out        = exe_out_r;
    assign exe_dst_reg    = dst_r;
    assign exe_en         = exe_en_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign mem_req_valid  = req_valid_r;
    assign mem_req_addr   = req_addr_r;
    assign mem_req_we     = req_we_r;
    assign mem_req_wdata  = req_wdata_r;

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: vector table, random ops against a reference model, directed sequences.
module tb_execute;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        src_a_en, src_b_en;
    logic [15:0] src_a, src_b;
    logic        i_alu_en;
    logic [3:0]  i_truth_table;
    logic [4:0]  i_alu_op;
    logic [3:0]  sh_off;
    logic        i_mem_en, i_mem_write;
    logic [31:0] mem_addr;
    logic        i_pc_set, i_pc_add, i_pc_inc;
    logic [30:0] pc;
    logic [3:0]  i_dst_reg;
    logic        i_wr_en;
    logic        exe_stall;
    logic [15:0] exe_out;
    logic [3:0]  exe_dst_reg;
    logic        exe_en;
    logic        redirect_valid;
    logic [30:0] redirect_pc;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [15:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;

    int n_cmp  = 0;
    int n_fail = 0;

    execute dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .src_a_en(src_a_en), .src_b_en(src_b_en), .src_a(src_a), .src_b(src_b),
        .i_alu_en(i_alu_en), .i_truth_table(i_truth_table), .i_alu_op(i_alu_op), .sh_off(sh_off),
        .i_mem_en(i_mem_en), .i_mem_write(i_mem_write), .mem_addr(mem_addr),
        .i_pc_set(i_pc_set), .i_pc_add(i_pc_add), .i_pc_inc(i_pc_inc), .pc(pc),
        .i_dst_reg(i_dst_reg), .i_wr_en(i_wr_en),
        .exe_stall(exe_stall), .exe_out(exe_out), .exe_dst_reg(exe_dst_reg), .exe_en(exe_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  tt;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic [3:0]  dst;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_alu_en = 1'b0; i_mem_en = 1'b0; i_mem_write = 1'b0;
        i_pc_set = 1'b0; i_pc_add = 1'b0; i_pc_inc = 1'b0; i_wr_en = 1'b0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " stall"}, exe_stall, 0);
        chk({nm, " out"}, exe_out, 0);
        chk({nm, " dst"}, exe_dst_reg, 0);
        chk({nm, " en"}, exe_en, 0);
        chk({nm, " redir_v"}, redirect_valid, 0);
        chk({nm, " redir_pc"}, redirect_pc, 0);
        chk({nm, " req_v"}, mem_req_valid, 0);
        chk({nm, " req_addr"}, mem_req_addr, 0);
        chk({nm, " req_we"}, mem_req_we, 0);
        chk({nm, " req_wdata"}, mem_req_wdata, 0);
    endtask

    // Reference: results computed straight from the op definitions with integer arithmetic
    function automatic logic [15:0] ref_alu(input int op, input logic [3:0] tt,
                                            input logic [15:0] a, input logic [15:0] b, input int sh);
        int ia, ib, r, s;
        ia = int'(a); ib = int'(b); r = 0;
        case (op)
            0: r = (ia + ib) % 65536;
            1: r = (ia - ib + 65536) % 65536;
            2: for (int i = 0; i < 16; i++) if (tt[2 * int'(a[i]) + int'(b[i])]) r += (1 << i);
            3: r = (ia << sh) % 65536;
            4: r = ia >> sh;
            5: begin
                s = (ia >= 32768) ? ia - 65536 : ia;
                r = (s >>> sh) & 32'hFFFF;
            end
            default: r = 0;
        endcase
        return r[15:0];
    endfunction

    task automatic run_alu(input string nm, input logic [4:0] op, input logic [3:0] tt,
                           input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh,
                           input logic [3:0] dst, input logic [15:0] exp);
        int k, lat, st;
        k = (op >= 5'd3 && op <= 5'd5 && sh != 4'd0) ? int'(sh) : 0;
        i_alu_en = 1'b1; i_alu_op = op; i_truth_table = tt; src_a = a; src_b = b;
        sh_off = sh; i_dst_reg = dst; i_wr_en = 1'b1;
        tick();
        clear_inputs();
        src_a = 16'($urandom); src_b = 16'($urandom); i_alu_op = 5'($urandom);
        sh_off = 4'($urandom); i_dst_reg = 4'($urandom);
        lat = 1; st = 0;
        while (!exe_en && lat < 40) begin
            if (exe_stall) st++;
            tick();
            lat++;
        end
        chk({nm, " latency"}, lat, k + 1);
        chk({nm, " stall_cycles"}, st, k);
        chk({nm, " out"}, exe_out, exp);
        chk({nm, " dst"}, exe_dst_reg, dst);
        chk({nm, " stall_done"}, exe_stall, 0);
        tick();
        chk({nm, " en_pulse"}, exe_en, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cpu_rst = 1'b0;
        src_a_en = 1'b1; src_b_en = 1'b1; src_a = '0; src_b = '0;
        i_truth_table = '0; i_alu_op = '0; sh_off = '0; mem_addr = '0; pc = '0;
        i_dst_reg = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        clear_inputs();

        vecs[0] = '{5'd0, 4'd0,    16'hFFFF, 16'h0002, 4'd0,  4'd3, 16'h0001};
        vecs[1] = '{5'd1, 4'd0,    16'h0000, 16'h0001, 4'd0,  4'd4, 16'hFFFF};
        vecs[2] = '{5'd2, 4'b0110, 16'hF0F0, 16'hFF00, 4'd0,  4'd5, 16'h0FF0};
        vecs[3] = '{5'd2, 4'b1000, 16'hF0F0, 16'hFF00, 4'd0,  4'd6, 16'hF000};
        vecs[4] = '{5'd2, 4'b1110, 16'hF0F0, 16'hFF00, 4'd0,  4'd7, 16'hFFF0};
        vecs[5] = '{5'd5, 4'd0,    16'h8001, 16'h0000, 4'd4,  4'd8, 16'hF800};
        vecs[6] = '{5'd3, 4'd0,    16'h0001, 16'h0000, 4'd15, 4'd9, 16'h8000};
        vecs[7] = '{5'd4, 4'd0,    16'h8000, 16'h0000, 4'd1,  4'd10, 16'h4000};
        vecs[8] = '{5'd4, 4'd0,    16'h1234, 16'h0000, 4'd0,  4'd11, 16'h1234};
        vecs[9] = '{5'd9, 4'd0,    16'h1234, 16'h5678, 4'd0,  4'd12, 16'h0000};

        repeat (3) tick();
        chk_all_zero("reset");
        @(negedge cpu_clk); cpu_rst = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_alu($sformatf("vec%0d", i), vecs[i].op, vecs[i].tt, vecs[i].a, vecs[i].b,
                    vecs[i].sh, vecs[i].dst, vecs[i].exp);
        end

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;  logic [3:0] tt, sh, dst;  logic [15:0] a, b;
            op = 5'($urandom_range(0, 7)); tt = 4'($urandom); sh = 4'($urandom);
            dst = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
            run_alu($sformatf("rand%0d", i), op, tt, a, b, sh, dst,
                    ref_alu(int'(op), tt, a, b, int'(sh)));
        end

        // ADD without write enable completes silently
        i_alu_en = 1'b1; i_alu_op = 5'd0; src_a = 16'h0001; src_b = 16'h0001; i_wr_en = 1'b0;
        tick(); clear_inputs();
        chk("nowr en", exe_en, 0);
        chk("nowr stall", exe_stall, 0);

        // Back-to-back single-cycle ops
        i_alu_en = 1'b1; i_wr_en = 1'b1; i_alu_op = 5'd0; src_a = 16'h0100; src_b = 16'h0023; i_dst_reg = 4'd1;
        tick();
        chk("b2b first en", exe_en, 1);
        chk("b2b first out", exe_out, 16'h0123);
        i_alu_op = 5'd1; src_a = 16'h0100; src_b = 16'h0001; i_dst_reg = 4'd2;
        tick(); clear_inputs();
        chk("b2b second en", exe_en, 1);
        chk("b2b second out", exe_out, 16'h00FF);
        chk("b2b second dst", exe_dst_reg, 2);
        tick();
        chk("b2b idle en", exe_en, 0);

        // Next instruction held during a shift is accepted only after IDLE is reached
        i_alu_en = 1'b1; i_wr_en = 1'b1; i_alu_op = 5'd4; src_a = 16'h00F0; sh_off = 4'd2; i_dst_reg = 4'd1;
        tick();
        i_alu_op = 5'd0; src_a = 16'h0010; src_b = 16'h0001; sh_off = 4'd0; i_dst_reg = 4'd2;
        chk("hold c1 stall", exe_stall, 1);
        chk("hold c1 en", exe_en, 0);
        tick();
        chk("hold c2 stall", exe_stall, 1);
        chk("hold c2 en", exe_en, 0);
        tick();
        chk("hold shift en", exe_en, 1);
        chk("hold shift out", exe_out, 16'h003C);
        chk("hold shift dst", exe_dst_reg, 1);
        tick(); clear_inputs();
        chk("hold add en", exe_en, 1);
        chk("hold add out", exe_out, 16'h0011);
        chk("hold add dst", exe_dst_reg, 2);
        tick();
        chk("hold idle en", exe_en, 0);

        // Load with delayed ready; stray response while requesting is ignored
        i_mem_en = 1'b1; i_mem_write = 1'b0; mem_addr = 32'h0000_1234; src_b = 16'h7777;
        i_dst_reg = 4'd5; i_wr_en = 1'b1;
        tick(); clear_inputs();
        mem_addr = 32'hFFFF_0000; src_b = 16'h0000;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("load wait%0d valid", c), mem_req_valid, 1);
            chk($sformatf("load wait%0d addr", c), mem_req_addr, 32'h0000_1234);
            chk($sformatf("load wait%0d we", c), mem_req_we, 0);
            chk($sformatf("load wait%0d stall", c), exe_stall, 1);
            chk($sformatf("load wait%0d en", c), exe_en, 0);
            mem_rsp_valid = (c == 1); mem_rsp_data = 16'hDEAD;
            tick();
            mem_rsp_valid = 1'b0;
        end
        chk("load hs en", exe_en, 0);
        chk("load hs valid", mem_req_valid, 1);
        chk("load hs addr", mem_req_addr, 32'h0000_1234);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("load after hs valid", mem_req_valid, 0);
        chk("load after hs stall", exe_stall, 1);
        tick();
        chk("load rsp wait stall", exe_stall, 1);
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'hBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("load en", exe_en, 1);
        chk("load out", exe_out, 16'hBEEF);
        chk("load dst", exe_dst_reg, 5);
        chk("load stall", exe_stall, 0);
        tick();
        chk("load en pulse", exe_en, 0);

        // Store with ready in the first request cycle
        mem_req_ready = 1'b1;
        i_mem_en = 1'b1; i_mem_write = 1'b1; i_alu_en = 1'b1; i_alu_op = 5'd0;
        mem_addr = 32'h00AB_CDEF; src_b = 16'h5A5A; i_dst_reg = 4'd6; i_wr_en = 1'b1;
        tick(); clear_inputs();
        chk("store valid", mem_req_valid, 1);
        chk("store we", mem_req_we, 1);
        chk("store wdata", mem_req_wdata, 16'h5A5A);
        chk("store addr", mem_req_addr, 32'h00AB_CDEF);
        chk("store stall", exe_stall, 1);
        chk("store en", exe_en, 0);
        tick();
        mem_req_ready = 1'b0;
        chk("store done valid", mem_req_valid, 0);
        chk("store done stall", exe_stall, 0);
        chk("store done en", exe_en, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'h1111;
        tick();
        mem_rsp_valid = 1'b0;
        chk("idle rsp en", exe_en, 0);

        // Redirects
        i_pc_set = 1'b1; pc = 31'h0000_1000;
        tick(); clear_inputs();
        chk("pcset valid", redirect_valid, 1);
        chk("pcset pc", redirect_pc, 31'h0000_1000);
        chk("pcset stall", exe_stall, 0);
        tick();
        chk("pcset pulse", redirect_valid, 0);
        i_pc_inc = 1'b1; pc = 31'h0000_2000;
        tick(); clear_inputs();
        chk("pcinc valid", redirect_valid, 0);
        i_pc_add = 1'b1; i_alu_en = 1'b1; i_alu_op = 5'd0; src_a = 16'h0003; src_b = 16'h0004;
        i_wr_en = 1'b1; i_dst_reg = 4'd7; pc = 31'h1234_5678;
        tick(); clear_inputs();
        chk("pcadd valid", redirect_valid, 1);
        chk("pcadd pc", redirect_pc, 31'h1234_5678);
        chk("pcadd en", exe_en, 1);
        chk("pcadd out", exe_out, 16'h0007);

        // Reset in the middle of a shift
        i_alu_en = 1'b1; i_wr_en = 1'b1; i_alu_op = 5'd3; src_a = 16'h0001; sh_off = 4'd10; i_dst_reg = 4'd9;
        tick(); clear_inputs();
        tick();
        chk("rst shift pre stall", exe_stall, 1);
        cpu_rst = 1'b0;
        #1;
        chk_all_zero("rst shift");
        @(negedge cpu_clk); cpu_rst = 1'b1;
        tick();
        run_alu("post rst shift add", 5'd0, 4'd0, 16'h1000, 16'h0234, 4'd0, 4'd2, 16'h1234);

        // Reset while a load request is outstanding; the late response is ignored
        i_mem_en = 1'b1; i_mem_write = 1'b0; mem_addr = 32'h0000_4444; i_wr_en = 1'b1; i_dst_reg = 4'd3;
        tick(); clear_inputs();
        chk("rst mem pre valid", mem_req_valid, 1);
        cpu_rst = 1'b0;
        #1;
        chk_all_zero("rst mem");
        @(negedge cpu_clk); cpu_rst = 1'b1;
        tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 16'hCAFE;
        tick();
        mem_rsp_valid = 1'b0;
        chk("rst mem late rsp en", exe_en, 0);
        chk("rst mem late rsp out", exe_out, 0);
        run_alu("post rst mem add", 5'd0, 4'd0, 16'hFFFF, 16'h0002, 4'd0, 4'd3, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/execute.md
# execute

Execute stage of the pipelined core, directly downstream of the `read` stage. It consumes resolved operands and ALU, memory and PC controls, and runs single-cycle ALU ops, multi-cycle serial shifts and memory transactions over a valid/ready port. It returns `exe_out`/`exe_dst_reg`/`exe_en` to `read` as the forwarding source, and issues branch redirects to fetch. It holds `read` with `exe_stall` while a multi-cycle operation is in progress.

## Interface
Parameters:
- `DATA_W`, 16: operand/result width.
- `PC_W`, 31: PC width.
- `ADDR_W`, 32: memory address width.

Ports:
- `cpu_clk` in 1: clock, rising edge.
- `cpu_rst` in 1: reset, asynchronous, active-low.
- `src_a_en`, `src_b_en` in 1: operand valid flags, forwarded from `read`.
- `src_a`, `src_b` in DATA_W: operands.
- `i_alu_en` in 1: ALU op present.
- `i_truth_table` in 4: logic op table.
- `i_alu_op` in 5: op select.
- `sh_off` in 4: shift amount, 0–15.
- `i_mem_en`, `i_mem_write` in 1: memory op present / store.
- `mem_addr` in ADDR_W: memory address.
- `i_pc_set`, `i_pc_add`, `i_pc_inc` in 1: PC action.
- `pc` in PC_W: target PC, already computed by `read`.
- `i_dst_reg` in 4: destination register.
- `i_wr_en` in 1: instruction writes `i_dst_reg`.
- `exe_stall` out 1: `read` must hold all inputs stable.
- `exe_out` out DATA_W: result.
- `exe_dst_reg` out 4: result destination.
- `exe_en` out 1: one-cycle pulse; result valid.
- `redirect_valid` out 1: one-cycle redirect pulse to fetch.
- `redirect_pc` out PC_W: redirect target.
- `mem_req_valid` out 1, `mem_req_ready` in 1: request handshake.
- `mem_req_addr` out ADDR_W, `mem_req_we` out 1, `mem_req_wdata` out DATA_W: request payload.
- `mem_rsp_valid` in 1, `mem_rsp_data` in DATA_W: load response.

## Operation
- Instruction present when `i_alu_en | i_mem_en | i_pc_set | i_pc_add | i_pc_inc`.
- An instruction is accepted on a rising edge where `exe_stall` = 0. Presence flags are ignored while stalled.
- FSM states: IDLE, SHIFT, MEM_REQ, MEM_WAIT. `exe_stall` = 1 in every state except IDLE.
- ALU ops:
  - ADD: `a+b` mod 2^16; carry discarded.
  - SUB: `a−b` mod 2^16.
  - LOGIC: result bit i = `i_truth_table[{a[i],b[i]}]`.
  - SHL / SHR / SRA: shift `src_a` by `sh_off`. SRA fills with `a[15]`.
  - Undefined op codes give result 0.
- Shift with `sh_off` = 0 completes as a single-cycle op. Otherwise:
  - Load the operand and count = `sh_off`, enter SHIFT.
  - Each edge shifts 1 bit and decrements the count.
  - On the edge where the count goes 1→0, write the result and return to IDLE.
- Memory op takes precedence over ALU when both flags are set. `mem_req_wdata` = `src_b`.
  - MEM_REQ: hold the request until `mem_req_ready`.
  - Store: return to IDLE and do not pulse `exe_en`.
  - Load: go to MEM_WAIT. On `mem_rsp_valid`, set `exe_out` = `mem_rsp_data`, pulse `exe_en`, go to IDLE.
- `exe_en` pulses only when `i_wr_en` was set at accept. `exe_dst_reg` is captured at accept.
- `i_pc_set | i_pc_add` at accept: pulse `redirect_valid` with `redirect_pc` = `pc`. This is independent of the ALU/memory path. `i_pc_inc` alone gives no redirect.

## Timing
- Reset: all outputs 0, FSM in IDLE. Reset takes effect immediately and asynchronously, including mid-shift or mid-transaction, and drops `mem_req_valid` at once. An outstanding response after reset is ignored.
- Single-cycle op accepted at edge N: `exe_en`/`exe_out` high in cycle N+1.
- Redirect accepted at edge N: `redirect_valid` high in cycle N+1 only.
- Shift by k ≥ 1 accepted at edge N:
  - `exe_stall` high in cycles N+1 … N+k.
  - `exe_en` high in cycle N+k+1.
- Memory request:
  - `mem_req_valid` rises in cycle N+1.
  - Address, write enable and data are stable until the edge where `valid & ready` are both high.
  - `mem_rsp_valid` arrives no earlier than one cycle after that handshake. A response in any other state is ignored.
- Back-to-back: a new instruction may be accepted on the same edge that returns the FSM to IDLE only for single-cycle ops. After multi-cycle ops, the next accept is the edge following the return to IDLE.
- `exe_en` is deasserted in every cycle with no completion.

## Structure
- Package `exec_pkg`: `alu_op_e` (ADD=0, SUB=1, LOGIC=2, SHL=3, SHR=4, SRA=5), `exec_state_e`, width constants.
- Sub-module `exec_alu`: combinational ADD/SUB/LOGIC. The serial shifter stays in `execute`.

## Test plan
- ADD 0xFFFF + 0x0002, `i_wr_en`=1, dst 3 → `exe_out`=0x0001, `exe_dst_reg`=3, `exe_en` for one cycle, one cycle after accept.
- LOGIC with `i_truth_table`=4'b0110 (XOR), a=0xF0F0, b=0xFF00 → `exe_out`=0x0FF0. SRA 0x8001 by 4 → 0xF800, `exe_stall` high for 4 cycles.
- Load at 0x00001234 with `mem_req_ready` delayed 3 cycles and response 0xBEEF two cycles later → request stable throughout, `exe_out`=0xBEEF.
- Store with ready on the first cycle → `mem_req_we`=1, `mem_req_wdata`=`src_b`, no `exe_en`, stall for 1 cycle.
- `i_pc_set` with `pc`=0x1000 → `redirect_valid` pulse, `redirect_pc`=0x1000. `i_pc_inc` alone → no redirect.
- `cpu_rst` low during SHIFT and during MEM_REQ → all outputs 0 immediately. After release, an ADD completes normally.
